puf_resp_streamer: RTL and testbench

- Downstream consumer of the 128-bit PUF response generator.
- Captures the 128-bit response when the generator's done flag rises, then emits it as a framed byte stream on a valid/ready interface for the UART/host link.
- Frame: header byte, then RESP_W/8 data bytes MSB-first, then an optional CRC-8 byte.
- Supports host-requested replay of the last captured response.

---
 rtl/puf_stream_pkg.sv | 9 +
 rtl/puf_resp_streamer_crc8_step.sv | 20 ++
 rtl/puf_resp_streamer.sv | 151 +++++++++++++++
 tb/tb_puf_resp_streamer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_stream_pkg.sv
// puf_stream_pkg: shared state encoding and constants for the PUF response streamer
package puf_stream_pkg;

    typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, DONE} state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY        = 8'h07;

endpackage

// File: rtl/puf_resp_streamer_crc8_step.sv
// crc8_step: one-byte combinational CRC-8 update (MSB-first, no reflection)
module crc8_step
    import puf_stream_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // fold the byte in, then shift out eight bits against the polynomial
    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        crc_out = c;
    end

endmodule

// File: rtl/puf_resp_streamer.sv
// puf_resp_streamer: captures the PUF response and streams it as a framed byte stream; PUF_STREAM_CRC8_EN appends a CRC-8 trailer
module puf_resp_streamer
    import puf_stream_pkg::*;
#(
    parameter int         RESP_W   = 128,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RESP_W-1:0] puf_out,
    input  logic              puf_done,
    input  logic              resend_req,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int NUM_BYTES = RESP_W / 8;
    localparam int CNT_W     = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

    state_e                  state_q, state_d;
    logic [RESP_W-1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    done_q;
    logic                    cap, xfer, restart;
    logic [CNT_W-1:0]        nxt_cnt, byte_idx;
    logic [NUM_BYTES-1:0][7:0] shadow_b;

    assign cap      = puf_done & ~done_q;
    assign xfer     = tx_valid_q & tx_ready;
    assign busy     = state_q inside {HDR, DATA, CRC};
    assign restart  = cap || (state_q == DONE && resend_req);
    assign nxt_cnt  = cnt_q + 1'b1;
    assign byte_idx = LAST - nxt_cnt;
    assign shadow_b = shadow_q;

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

`ifdef PUF_STREAM_CRC8_EN
    logic [7:0] crc_q, crc_d, crc_nx;

    crc8_step u_crc (
        .crc_in  (crc_q),
        .data_in (tx_data_q),
        .crc_out (crc_nx)
    );
`endif

    // frame sequencing: capture/replay start, byte advance, trailer and completion
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (cap & busy);
`ifdef PUF_STREAM_CRC8_EN
        crc_d        = crc_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (restart) begin
                    shadow_d   = cap ? puf_out : shadow_q;
                    cnt_d      = '0;
                    tx_data_d  = HDR_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = HDR;
`ifdef PUF_STREAM_CRC8_EN
                    crc_d      = '0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    tx_data_d = shadow_q[RESP_W-1 -: 8];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef PUF_STREAM_CRC8_EN
                    crc_d = crc_nx;
`endif
                    if (cnt_q != LAST) begin
                        cnt_d     = nxt_cnt;
                        tx_data_d = shadow_b[byte_idx];
                    end else begin
`ifdef PUF_STREAM_CRC8_EN
                        tx_data_d = crc_nx;
                        state_d   = CRC;
`else
                        frame_done_d = 1'b1;
                        tx_valid_d   = 1'b0;
                        state_d      = DONE;
`endif
                    end
                end
            end
            CRC: begin
                if (xfer) begin
                    frame_done_d = 1'b1;
                    tx_valid_d   = 1'b0;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
`ifdef PUF_STREAM_CRC8_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            done_q       <= puf_done;
`ifdef PUF_STREAM_CRC8_EN
            crc_q        <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_puf_resp_streamer.sv
// tb_puf_resp_streamer: scoreboard bench for puf_resp_streamer (CRC trailer expected when PUF_STREAM_CRC8_EN is defined)
module tb_puf_resp_streamer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] puf_out = '0;
    logic         puf_done = 1'b0;
    logic         resend_req = 1'b0;
    logic         tx_ready = 1'b1;
    logic         tx_valid, busy, frame_done, overrun;
    logic [7:0]   tx_data;

    puf_resp_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .puf_out    (puf_out),
        .puf_done   (puf_done),
        .resend_req (resend_req),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] D_BASIC = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D_BP    = 128'h5468697349734E6F74576F726B696E67;
    localparam logic [127:0] D_B     = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    localparam logic [127:0] D_C     = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    localparam logic [127:0] D_D     = 128'h13579BDF2468ACE0A1B2C3D4E5F60718;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_xfer = 0;
    logic [7:0] exp_q[$];
    bit         fd_pend = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] hold_d = '0;
    logic [3:0] pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [127:0] d);
        logic [7:0] c = '0;
        logic       fb;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic push_frame(input logic [127:0] d);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) exp_q.push_back(d[127-8*i -: 8]);
`ifdef PUF_STREAM_CRC8_EN
        exp_q.push_back(crc_model(d));
`endif
    endtask

    task automatic drain(input bit bp);
        int k = 0;
        do begin
            @(posedge clk); #1;
            tx_ready = bp ? pat[k % 4] : 1'b1;
            k++;
        end while ((exp_q.size() != 0 || busy || tx_valid) && k < 400);
        if (k >= 400) check("drain_timeout", exp_q.size(), 0);
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic new_capture(input logic [127:0] d, input bit bp);
        @(posedge clk); #1;
        puf_done = 1'b0;
        @(posedge clk); #1;
        puf_out  = d;
        puf_done = 1'b1;
        push_frame(d);
        drain(bp);
    endtask

    // monitor: pop the scoreboard on every transfer, check stall hold and frame_done timing
    always @(negedge clk) begin
        if (!rst) begin
            check("frame_done", frame_done, fd_pend);
            fd_pend = 1'b0;
            if (stall_prev) check("hold_data", tx_data, hold_d);
            if (tx_valid && tx_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) check("extra_valid", tx_valid, 0);
                else begin
                    check("byte", tx_data, exp_q.pop_front());
                    if (exp_q.size() == 0) fd_pend = 1'b1;
                end
            end
            stall_prev = tx_valid && !tx_ready;
            hold_d     = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int start;
        #12;
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        // replay request in IDLE produces nothing
        @(posedge clk); #1;
        resend_req = 1'b1;
        @(posedge clk); #1;
        resend_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_resend_valid", tx_valid, 0);
        check("idle_resend_busy", busy, 0);
        // basic frame with header latency of one edge
        puf_out  = D_BASIC;
        puf_done = 1'b1;
        push_frame(D_BASIC);
        @(negedge clk);
        check("lat_pre", tx_valid, 0);
        @(negedge clk);
        check("lat_valid", tx_valid, 1);
        check("lat_busy", busy, 1);
        drain(1'b0);
        check("basic_busy", busy, 0);
        check("basic_valid", tx_valid, 0);
        check("basic_overrun", overrun, 0);
        // all-zero and single-bit data (CRC trailers 00 and 07 when enabled)
        new_capture(128'h0, 1'b0);
        new_capture(128'h1, 1'b0);
        check("crc_model_1", crc_model(128'h1), 8'h07);
        // backpressure 1,0,0,1
        new_capture(D_BP, 1'b1);
        // overrun: new edge mid-DATA leaves the running frame untouched
        @(posedge clk); #1;
        puf_done = 1'b0;
        @(posedge clk); #1;
        puf_out  = D_BASIC;
        puf_done = 1'b1;
        push_frame(D_BASIC);
        repeat (6) @(posedge clk);
        #1;
        puf_done = 1'b0;
        @(posedge clk); #1;
        puf_out  = D_B;
        puf_done = 1'b1;
        @(posedge clk); #1;
        check("ovr_busy", busy, 1);
        drain(1'b0);
        check("ovr_flag", overrun, 1);
        repeat (10) @(posedge clk);
        #1;
        check("ovr_no_new", tx_valid, 0);
        // resend in DONE replays the original shadow
        resend_req = 1'b1;
        push_frame(D_BASIC);
        @(posedge clk); #1;
        resend_req = 1'b0;
        drain(1'b0);
        check("resend_overrun_sticky", overrun, 1);
        // resend together with a new edge: new data wins
        puf_done = 1'b0;
        @(posedge clk); #1;
        puf_out    = D_C;
        puf_done   = 1'b1;
        resend_req = 1'b1;
        push_frame(D_C);
        @(posedge clk); #1;
        resend_req = 1'b0;
        drain(1'b0);
        // async reset during byte 5, then fresh frame from held puf_done
        puf_done = 1'b0;
        @(posedge clk); #1;
        puf_out  = D_D;
        puf_done = 1'b1;
        push_frame(D_D);
        start = n_xfer;
        for (int k = 0; k < 50 && n_xfer < start + 5; k++) @(posedge clk);
        check("rst_wait", n_xfer - start, 5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", tx_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_fdone", frame_done, 0);
        exp_q.delete();
        fd_pend    = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        push_frame(D_D);
        @(negedge clk);
        check("post_rst_valid", tx_valid, 1);
        drain(1'b0);
        check("post_rst_busy", busy, 0);
        check("post_rst_overrun", overrun, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
